snow64_lar_mem_bridge: RTL and testbench
========================================

# snow64_lar_mem_bridge

Memory-side responder for the LAR file's line-sized memory requests. It accepts the LAR file's read-fill and write-back requests (256-bit line, 59-bit base address) and services each as four 64-bit beats on the CPU's simple request/acknowledge memory bus. When a line transfer finishes, it returns a one-cycle `valid` pulse, plus line data for reads. It sits between the LAR file and the memory arbiter.

## Interface
Parameters:
- none. Widths come from `snow64_lar_file_defines`: line 256 b, base address 59 b, CPU address 64 b.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_lar_mem_read_req`  in  1  LAR file requests a line fill (level).
- `in_lar_mem_read_base_addr`  in  59  line base address for the fill.
- `in_lar_mem_write_req`  in  1  LAR file requests a write-back (level).
- `in_lar_mem_write_base_addr`  in  59  line base address for the write-back.
- `in_lar_mem_write_data`  in  256  line to write.
- `out_lar_mem_read_valid`  out  1  one-cycle pulse: fill complete.
- `out_lar_mem_read_data`  out  256  filled line; valid only while `out_lar_mem_read_valid` is high.
- `out_lar_mem_write_valid`  out  1  one-cycle pulse: write-back complete.
- `out_bus_req`  out  1  bus beat request.
- `out_bus_we`  out  1  1 = write beat.
- `out_bus_addr`  out  64  byte address of the beat, equal to `{base_addr, beat[1:0], 3'b000}`.
- `out_bus_wdata`  out  64  write beat data.
- `in_bus_ack`  in  1  beat accepted or completed.
- `in_bus_rdata`  in  64  read beat data; valid when `in_bus_ack` is high.

## Operation
- States: `StIdle`, `StWrBeat`, `StWrResp`, `StRdBeat`, `StRdResp`.
- In `StIdle`, requests are sampled and registered, including address and write data.
  - Write only: go to `StWrBeat`.
  - Read only: go to `StRdBeat`.
  - Both high: go to `StWrBeat`, then `StRdBeat`. The write-back always precedes the fill.
- `StWrBeat`/`StRdBeat`:
  - `out_bus_req` stays high.
  - Each `in_bus_ack` advances the 2-bit beat counter, starting at 0.
  - Beat k carries line bits `[64k+63:64k]`, little-endian.
  - Read beats are written into the line register at slot k.
  - The ack on beat 3 moves the block to the matching `*Resp` state.
- `StWrResp`: pulse `out_lar_mem_write_valid`. Next state is `StRdBeat` if a read is pending, else `StIdle`.
- `StRdResp`: pulse `out_lar_mem_read_valid` with the assembled line, then go to `StIdle`.
- Requester rule: drop each `req` in the cycle its `valid` is seen, before the next edge. Requests are not re-sampled until the FSM is back in `StIdle`.
- A pending read's address is latched at capture. Later changes on the input are ignored.

## Timing
- Reset (async, immediate):
  - state is `StIdle`;
  - beat counter is 0;
  - `out_bus_req`, `out_bus_we`, and both `valid` outputs are 0;
  - `out_bus_addr`, `out_bus_wdata`, and `out_lar_mem_read_data` are 0.
- Reset mid-transfer abandons the transfer with no `valid` pulse. The bus slave must tolerate a dropped `req`.
- Latency with zero-wait acks, measured from the request-sampling edge:
  - write-back: 4 beat cycles, then 1 response cycle, so 5 cycles to the `valid` pulse;
  - read: 5 cycles;
  - combined: 10 cycles, ending with the read `valid`.
- Wait states extend beats indefinitely. There is no timeout.
- `out_bus_addr`, `out_bus_we`, and `out_bus_wdata` are registered. They change only on the edge following an ack or a state entry, never while an ack is outstanding.
- `out_bus_req` stays high across consecutive beats of the same phase. It is low for at least one cycle between the write phase and the read phase, because `StWrResp` intervenes.
- The beat counter wraps 3→0 on phase exit.

## Configuration
- `SNOW64_LAR_MEM_BRIDGE_FWD_EN` defined:
  - applies to a combined request whose read and write base addresses are equal;
  - the bus read phase is skipped;
  - `StWrResp` goes to `StRdResp`, which returns the captured write data;
  - combined latency becomes 6 cycles.
- Undefined: the read is always issued to the bus.

## Structure
- `PkgSnow64LarFile` gains:
  - `LarMemBridgeState` enum (3 bits);
  - `LarMemBeatIndex` (2 bits);
  - localparam `LAR_MEM_BEATS_PER_LINE = 4`;
  - `PartialPortIn_LarMemBridge_Bus`;
  - `PartialPortOut_LarMemBridge_Bus`.
- Sub-module `snow64_lar_line_beat_mux` (combinational): selects the write beat and assembles read beats by index.

## Test plan
- Read only, base `59'h1`, zero-wait bus returning beats `64'hA0..A3`:
  - bus addresses are 0x20, 0x28, 0x30, 0x38;
  - `out_lar_mem_read_valid` pulses 5 cycles after capture;
  - data is `{A3,A2,A1,A0}`.
- Write only, data `256'h3333_…_0000` (beat k = `64'hkkkk…`), acks with 2 wait states each:
  - `out_bus_we` is 1 for all beats;
  - wdata order is beat 0 to beat 3;
  - `out_lar_mem_write_valid` pulses once, 13 cycles after capture.
- Simultaneous write base `0x10` and read base `0x20`:
  - all 4 write beats precede the read beats;
  - the write `valid` precedes the read `valid`;
  - `out_bus_req` is low during `StWrResp`.
- Same base `0x10` for both requests, with `FWD_EN`:
  - no read beats on the bus;
  - the read `valid` returns the write data at cycle 6.
  - Without `FWD_EN`: 4 read beats are issued.
- `rst` asserted after beat 1 of a read:
  - outputs are 0 immediately;
  - no `valid` pulse;
  - a new read after release starts at beat 0.
- Requester holds `req` one cycle past `valid`: a second transfer starts, and the bench flags this as a protocol violation.

Source files
------------

// File: rtl/PkgSnow64LarFile.sv
// PkgSnow64LarFile
// Shared types and widths for the LAR file's memory-side bridge.
//   - line 256 b, base address 59 b, CPU byte address 64 b
//   - LarMemBridgeState: bridge FSM encoding
//   - LarMemBeatIndex: 64-bit beat slot within a line
//   - PartialPortIn/Out_LarMemBridge_Bus: bridge's view of the CPU memory bus
package PkgSnow64LarFile;

    localparam int unsigned LAR_LINE_WIDTH         = 256;
    localparam int unsigned LAR_BASE_ADDR_WIDTH    = 59;
    localparam int unsigned CPU_ADDR_WIDTH         = 64;
    localparam int unsigned LAR_MEM_BEAT_WIDTH     = 64;
    localparam int unsigned LAR_MEM_BEATS_PER_LINE = 4;

    typedef logic [1:0] LarMemBeatIndex;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrBeat = 3'd1,
        StWrResp = 3'd2,
        StRdBeat = 3'd3,
        StRdResp = 3'd4
    } LarMemBridgeState;

    typedef struct packed {
        logic        ack;
        logic [63:0] rdata;
    } PartialPortIn_LarMemBridge_Bus;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } PartialPortOut_LarMemBridge_Bus;

    // Byte address of one beat: line base, beat slot, 8-byte offset.
    function automatic logic [63:0] lar_mem_beat_addr(input logic [58:0] base,
                                                      input LarMemBeatIndex beat);
        return {base, beat, 3'b000};
    endfunction

endpackage

// File: rtl/snow64_lar_line_beat_mux.sv
// snow64_lar_line_beat_mux
// Combinational beat steering between a 256-bit line and 64-bit bus beats.
//   wr_line_i / wr_idx_i -> wr_beat_o    : beat k = line[64k+63:64k]
//   rd_line_i / rd_idx_i / rd_beat_i -> rd_line_o : line with slot k replaced
module snow64_lar_line_beat_mux
    import PkgSnow64LarFile::*;
(
    input  logic [255:0]   wr_line_i,
    input  LarMemBeatIndex wr_idx_i,
    output logic [63:0]    wr_beat_o,
    input  logic [255:0]   rd_line_i,
    input  LarMemBeatIndex rd_idx_i,
    input  logic [63:0]    rd_beat_i,
    output logic [255:0]   rd_line_o
);

    always_comb begin
        wr_beat_o = wr_line_i[{wr_idx_i, 6'b000000} +: 64];
        rd_line_o = rd_line_i;
        rd_line_o[{rd_idx_i, 6'b000000} +: 64] = rd_beat_i;
    end

endmodule

// File: rtl/snow64_lar_mem_bridge.sv
// snow64_lar_mem_bridge
// Services LAR file line fills / write-backs as four 64-bit beats on the CPU
// req/ack memory bus, then pulses a one-cycle valid (with the line for fills).
//   clk, rst                        : clock, async active-high reset
//   in_lar_mem_read_*               : fill request (level) + base address
//   in_lar_mem_write_*              : write-back request (level) + base + line
//   out_lar_mem_read_valid/data     : fill complete pulse + assembled line
//   out_lar_mem_write_valid         : write-back complete pulse
//   out_bus_req/we/addr/wdata       : registered bus beat request
//   in_bus_ack/rdata                : beat accepted / read beat data
// Build option: define SNOW64_LAR_MEM_BRIDGE_FWD_EN to answer a combined
// request with equal bases from the write-back line, skipping the bus fill.
module snow64_lar_mem_bridge
    import PkgSnow64LarFile::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_lar_mem_read_req,
    input  logic [58:0]  in_lar_mem_read_base_addr,
    input  logic         in_lar_mem_write_req,
    input  logic [58:0]  in_lar_mem_write_base_addr,
    input  logic [255:0] in_lar_mem_write_data,
    output logic         out_lar_mem_read_valid,
    output logic [255:0] out_lar_mem_read_data,
    output logic         out_lar_mem_write_valid,
    output logic         out_bus_req,
    output logic         out_bus_we,
    output logic [63:0]  out_bus_addr,
    output logic [63:0]  out_bus_wdata,
    input  logic         in_bus_ack,
    input  logic [63:0]  in_bus_rdata
);

    localparam LarMemBeatIndex BEAT_LAST = LarMemBeatIndex'(LAR_MEM_BEATS_PER_LINE - 1);

    LarMemBridgeState               state_q, state_d;
    LarMemBeatIndex                 beat_q, beat_d;
    logic                           rd_pending_q, rd_pending_d;
    logic                           fwd_q, fwd_d;
    logic [58:0]                    wr_addr_q, wr_addr_d;
    logic [58:0]                    rd_addr_q, rd_addr_d;
    logic [255:0]                   wr_line_q, wr_line_d;
    logic [255:0]                   rd_line_q, rd_line_d;
    logic                           wr_valid_q, wr_valid_d;
    logic                           rd_valid_q, rd_valid_d;
    PartialPortOut_LarMemBridge_Bus bus_q, bus_d;
    PartialPortIn_LarMemBridge_Bus  bus_in;

    LarMemBeatIndex beat_nxt;
    LarMemBeatIndex wr_sel_idx;
    logic [255:0]   wr_sel_line;
    logic [63:0]    wr_beat;
    logic [255:0]   rd_line_asm;
    logic           fwd_match;

    assign bus_in   = {in_bus_ack, in_bus_rdata};
    assign beat_nxt = beat_q + 2'd1;

    // In idle the first write beat comes straight from the input line so
    // wdata is registered on the capture edge; afterwards from the held line.
    assign wr_sel_line = (state_q == StIdle) ? in_lar_mem_write_data : wr_line_q;
    assign wr_sel_idx  = (state_q == StIdle) ? '0 : beat_nxt;

`ifdef SNOW64_LAR_MEM_BRIDGE_FWD_EN
    assign fwd_match = in_lar_mem_read_req
                       && (in_lar_mem_read_base_addr == in_lar_mem_write_base_addr);
`else
    assign fwd_match = 1'b0;
`endif

    snow64_lar_line_beat_mux u_beat_mux (
        .wr_line_i (wr_sel_line),
        .wr_idx_i  (wr_sel_idx),
        .wr_beat_o (wr_beat),
        .rd_line_i (rd_line_q),
        .rd_idx_i  (beat_q),
        .rd_beat_i (bus_in.rdata),
        .rd_line_o (rd_line_asm)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        rd_pending_d = rd_pending_q;
        fwd_d        = fwd_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_line_d    = wr_line_q;
        rd_line_d    = rd_line_q;
        wr_valid_d   = 1'b0;
        rd_valid_d   = 1'b0;
        bus_d        = bus_q;

        unique case (state_q)
            StIdle: begin
                rd_addr_d = in_lar_mem_read_base_addr;
                if (in_lar_mem_write_req) begin
                    // Write-back always goes first; a concurrent fill waits.
                    state_d      = StWrBeat;
                    wr_addr_d    = in_lar_mem_write_base_addr;
                    wr_line_d    = in_lar_mem_write_data;
                    rd_pending_d = in_lar_mem_read_req;
                    fwd_d        = fwd_match;
                    bus_d.req    = 1'b1;
                    bus_d.we     = 1'b1;
                    bus_d.addr   = lar_mem_beat_addr(in_lar_mem_write_base_addr, '0);
                    bus_d.wdata  = wr_beat;
                end else if (in_lar_mem_read_req) begin
                    state_d     = StRdBeat;
                    bus_d.req   = 1'b1;
                    bus_d.we    = 1'b0;
                    bus_d.addr  = lar_mem_beat_addr(in_lar_mem_read_base_addr, '0);
                    bus_d.wdata = '0;
                end
            end
            StWrBeat: begin
                if (bus_in.ack) begin
                    beat_d = beat_nxt;
                    if (beat_q == BEAT_LAST) begin
                        state_d    = StWrResp;
                        wr_valid_d = 1'b1;
                        bus_d      = '0;
                    end else begin
                        bus_d.addr  = lar_mem_beat_addr(wr_addr_q, beat_nxt);
                        bus_d.wdata = wr_beat;
                    end
                end
            end
            StWrResp: begin
                rd_pending_d = 1'b0;
                fwd_d        = 1'b0;
                if (!rd_pending_q) begin
                    state_d = StIdle;
                end else if (fwd_q) begin
                    state_d    = StRdResp;
                    rd_valid_d = 1'b1;
                    rd_line_d  = wr_line_q;
                end else begin
                    state_d     = StRdBeat;
                    bus_d.req   = 1'b1;
                    bus_d.we    = 1'b0;
                    bus_d.addr  = lar_mem_beat_addr(rd_addr_q, '0);
                    bus_d.wdata = '0;
                end
            end
            StRdBeat: begin
                if (bus_in.ack) begin
                    beat_d    = beat_nxt;
                    rd_line_d = rd_line_asm;
                    if (beat_q == BEAT_LAST) begin
                        state_d    = StRdResp;
                        rd_valid_d = 1'b1;
                        bus_d      = '0;
                    end else begin
                        bus_d.addr = lar_mem_beat_addr(rd_addr_q, beat_nxt);
                    end
                end
            end
            StRdResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            rd_pending_q <= 1'b0;
            fwd_q        <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_line_q    <= '0;
            rd_line_q    <= '0;
            wr_valid_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            bus_q        <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            rd_pending_q <= rd_pending_d;
            fwd_q        <= fwd_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_line_q    <= wr_line_d;
            rd_line_q    <= rd_line_d;
            wr_valid_q   <= wr_valid_d;
            rd_valid_q   <= rd_valid_d;
            bus_q        <= bus_d;
        end
    end

    assign out_lar_mem_read_valid  = rd_valid_q;
    assign out_lar_mem_read_data   = rd_line_q;
    assign out_lar_mem_write_valid = wr_valid_q;
    assign out_bus_req             = bus_q.req;
    assign out_bus_we              = bus_q.we;
    assign out_bus_addr            = bus_q.addr;
    assign out_bus_wdata           = bus_q.wdata;

endmodule

// File: tb/tb_snow64_lar_mem_bridge.sv
// tb_snow64_lar_mem_bridge
// Scoreboard bench: each transfer pushes its expected bus beats and valid
// pulses (kind, cycle, line) when driven; monitors pop and compare as the
// bridge produces them. A wait-state bus slave returns a fixed memory pattern.
module tb_snow64_lar_mem_bridge;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_lar_mem_read_req = 1'b0;
    logic [58:0]  in_lar_mem_read_base_addr = '0;
    logic         in_lar_mem_write_req = 1'b0;
    logic [58:0]  in_lar_mem_write_base_addr = '0;
    logic [255:0] in_lar_mem_write_data = '0;
    logic         out_lar_mem_read_valid;
    logic [255:0] out_lar_mem_read_data;
    logic         out_lar_mem_write_valid;
    logic         out_bus_req;
    logic         out_bus_we;
    logic [63:0]  out_bus_addr;
    logic [63:0]  out_bus_wdata;
    logic         in_bus_ack = 1'b0;
    logic [63:0]  in_bus_rdata = '0;

    snow64_lar_mem_bridge dut (
        .clk                        (clk),
        .rst                        (rst),
        .in_lar_mem_read_req        (in_lar_mem_read_req),
        .in_lar_mem_read_base_addr  (in_lar_mem_read_base_addr),
        .in_lar_mem_write_req       (in_lar_mem_write_req),
        .in_lar_mem_write_base_addr (in_lar_mem_write_base_addr),
        .in_lar_mem_write_data      (in_lar_mem_write_data),
        .out_lar_mem_read_valid     (out_lar_mem_read_valid),
        .out_lar_mem_read_data      (out_lar_mem_read_data),
        .out_lar_mem_write_valid    (out_lar_mem_write_valid),
        .out_bus_req                (out_bus_req),
        .out_bus_we                 (out_bus_we),
        .out_bus_addr               (out_bus_addr),
        .out_bus_wdata              (out_bus_wdata),
        .in_bus_ack                 (in_bus_ack),
        .in_bus_rdata               (in_bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        bit           is_rd;
        int unsigned  cyc;
        logic [255:0] data;
    } vld_t;

    beat_t exp_beats[$];
    vld_t  exp_vld[$];

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;
    int unsigned cyc = 0;
    int unsigned beats_seen = 0;
    int unsigned valid_pulses = 0;
    int unsigned proto_viol = 0;
    int unsigned ws_cfg = 0;
    int unsigned wcnt = 0;
    bit          phase_seen = 0;
    logic        last_we_phase = 1'b0;
    logic        prev_req = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Memory image: low byte A0+slot, upper bits (line base - 1).
    function automatic logic [63:0] rd_model(input logic [63:0] a);
        logic [63:0] hi;
        hi = {5'b0, a[63:5]} - 64'd1;
        return (hi << 8) | (64'hA0 + {62'b0, a[4:3]});
    endfunction

    function automatic logic [255:0] model_line(input logic [58:0] base);
        logic [255:0] l;
        for (int k = 0; k < 4; k++) l[k*64 +: 64] = rd_model({base, 2'(k), 3'b000});
        return l;
    endfunction

    always @(posedge clk) cyc++;

    // Bus slave: ack after ws_cfg wait cycles per beat.
    always @(posedge clk) begin
        #1;
        if (!rst && out_bus_req) begin
            if (wcnt >= ws_cfg) begin
                in_bus_ack   = 1'b1;
                in_bus_rdata = out_bus_we ? 64'd0 : rd_model(out_bus_addr);
                wcnt         = 0;
            end else begin
                in_bus_ack = 1'b0;
                wcnt++;
            end
        end else begin
            in_bus_ack = 1'b0;
            wcnt       = 0;
        end
    end

    // Requester must have dropped req by the edge that ends its valid pulse.
    always @(posedge clk) begin
        if (!rst && ((out_lar_mem_write_valid && in_lar_mem_write_req) ||
                     (out_lar_mem_read_valid && in_lar_mem_read_req))) begin
            proto_viol++;
            $display("[TB] protocol violation: req held past valid at cycle %0d", cyc);
        end
    end

    task automatic check_vld(input bit is_rd);
        vld_t e;
        check_eq(is_rd ? "rd_valid_expected" : "wr_valid_expected", exp_vld.size() != 0, 1);
        if (exp_vld.size() != 0) begin
            e = exp_vld.pop_front();
            check_eq("valid_kind", is_rd, e.is_rd);
            check_eq(is_rd ? "rd_valid_cycle" : "wr_valid_cycle", cyc, e.cyc);
            if (is_rd) check_eq("rd_line_data", out_lar_mem_read_data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (out_lar_mem_write_valid || out_lar_mem_read_valid) valid_pulses++;
        if (!rst) begin
            if (out_bus_req && !out_bus_we && phase_seen && last_we_phase)
                check_eq("wr_rd_gap_req", prev_req, 1'b0);
            if (out_bus_req && in_bus_ack) begin
                beats_seen++;
                check_eq("beat_expected", exp_beats.size() != 0, 1);
                if (exp_beats.size() != 0) begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    check_eq("beat_we", out_bus_we, e.we);
                    check_eq("beat_addr", out_bus_addr, e.addr);
                    if (e.we) check_eq("beat_wdata", out_bus_wdata, e.wdata);
                end
            end
            if (out_bus_req) begin
                phase_seen    = 1;
                last_we_phase = out_bus_we;
            end
            if (out_lar_mem_write_valid) check_vld(0);
            if (out_lar_mem_read_valid) check_vld(1);
            prev_req = out_bus_req;
        end
    end

    task automatic push_line_beats(input bit we, input logic [58:0] base, input logic [255:0] wd);
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.we    = we;
            b.addr  = {base, 2'(k), 3'b000};
            b.wdata = we ? wd[k*64 +: 64] : 64'd0;
            exp_beats.push_back(b);
        end
    endtask

    task automatic push_vld(input bit is_rd, input int unsigned c, input logic [255:0] d);
        vld_t v;
        v.is_rd = is_rd;
        v.cyc   = c;
        v.data  = d;
        exp_vld.push_back(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_beats.size() != 0 || exp_vld.size() != 0); i++)
            @(negedge clk);
        check_eq("drain_beats", exp_beats.size(), 0);
        check_eq("drain_valids", exp_vld.size(), 0);
        exp_beats.delete();
        exp_vld.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_xfer(input bit wr, input bit rd, input logic [58:0] wa,
                           input logic [58:0] ra, input logic [255:0] wd,
                           input int unsigned ws);
        int unsigned n, bl;
        bit fwd;
        @(posedge clk);
        #2;
        ws_cfg = ws;
        n      = cyc;
        bl     = 4 * (ws + 1) + 1;
        fwd    = 0;
`ifdef SNOW64_LAR_MEM_BRIDGE_FWD_EN
        fwd = wr && rd && (wa == ra);
`endif
        if (wr) begin
            push_line_beats(1, wa, wd);
            push_vld(0, n + bl, '0);
        end
        if (rd) begin
            if (!fwd) push_line_beats(0, ra, '0);
            push_vld(1, !wr ? n + bl : (fwd ? n + bl + 1 : n + 2 * bl),
                     fwd ? wd : model_line(ra));
        end
        in_lar_mem_write_base_addr = wa;
        in_lar_mem_write_data      = wd;
        in_lar_mem_read_base_addr  = ra;
        in_lar_mem_write_req       = wr;
        in_lar_mem_read_req        = rd;
        for (int i = 0; i < 600 && (in_lar_mem_write_req || in_lar_mem_read_req); i++) begin
            @(negedge clk);
            if (i == 1) in_lar_mem_read_base_addr = ~ra;
            if (out_lar_mem_write_valid) in_lar_mem_write_req = 1'b0;
            if (out_lar_mem_read_valid) in_lar_mem_read_req = 1'b0;
        end
        check_eq("xfer_reqs_released", {in_lar_mem_write_req, in_lar_mem_read_req}, 2'b00);
        in_lar_mem_write_req = 1'b0;
        in_lar_mem_read_req  = 1'b0;
        drain();
    endtask

    localparam logic [255:0] WD_STEP = {{4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}, 64'h0};

    initial begin
        int unsigned n, b0, vp0, pv0;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check_eq("rst_bus_req", out_bus_req, 0);
        check_eq("rst_bus_we", out_bus_we, 0);
        check_eq("rst_bus_addr", out_bus_addr, 0);
        check_eq("rst_bus_wdata", out_bus_wdata, 0);
        check_eq("rst_rd_valid", out_lar_mem_read_valid, 0);
        check_eq("rst_wr_valid", out_lar_mem_write_valid, 0);
        check_eq("rst_rd_data", out_lar_mem_read_data, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        do_xfer(0, 1, 59'h0, 59'h1, '0, 0);
        do_xfer(1, 0, 59'h2, 59'h0, WD_STEP, 2);
        do_xfer(1, 1, 59'h10, 59'h20, {4{64'hDEAD_BEEF_0123_4567}}, 0);
        do_xfer(1, 1, 59'h10, 59'h10, {64'h4444, 64'h5555, 64'h6666, 64'h7777}, 0);
        do_xfer(1, 1, 59'h40, 59'h41, {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom}, 1);

        // Reset after beat 1 of a read
        @(posedge clk);
        #2;
        ws_cfg = 0;
        b0     = beats_seen;
        push_line_beats(0, 59'h7, '0);
        in_lar_mem_read_base_addr = 59'h7;
        in_lar_mem_read_req       = 1'b1;
        for (int i = 0; i < 50 && beats_seen < b0 + 2; i++) @(negedge clk);
        check_eq("rst_test_beats_seen", beats_seen - b0, 2);
        @(posedge clk);
        #2;
        rst                 = 1'b1;
        in_lar_mem_read_req = 1'b0;
        vp0                 = valid_pulses;
        #1;
        check_eq("midrst_bus_req", out_bus_req, 0);
        check_eq("midrst_bus_addr", out_bus_addr, 0);
        check_eq("midrst_rd_data", out_lar_mem_read_data, 0);
        exp_beats.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("midrst_no_valid", valid_pulses - vp0, 0);
        do_xfer(0, 1, 59'h0, 59'h5, '0, 0);

        // Requester holds write req one cycle past its valid
        @(posedge clk);
        #2;
        ws_cfg = 0;
        n      = cyc;
        pv0    = proto_viol;
        push_line_beats(1, 59'h30, WD_STEP);
        push_vld(0, n + 5, '0);
        push_line_beats(1, 59'h30, WD_STEP);
        push_vld(0, n + 11, '0);
        in_lar_mem_write_base_addr = 59'h30;
        in_lar_mem_write_data      = WD_STEP;
        in_lar_mem_write_req       = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_lar_mem_write_valid) break;
        end
        @(negedge clk);
        @(negedge clk);
        in_lar_mem_write_req = 1'b0;
        drain();
        check_eq("proto_viol_flagged", proto_viol - pv0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
